// File: rtl/rot_stream_pkg.sv
// Shared definitions for the rotating stream block: operand widths,
// direction encoding and the direction-to-amount mapping used by the top.
package rot_stream_pkg;

   localparam int ROT_W = 8;
   localparam int AMT_W = 3;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef logic [ROT_W-1:0] rot_data_t;
   typedef logic [AMT_W-1:0] rot_amt_t;

   // A left rotate by n equals a right rotate by (8 - n) mod 8, so the
   // rotator itself only ever needs to rotate right.
   function automatic rot_amt_t map_amt(input logic dir, input rot_amt_t amt);
      rot_amt_t mapped;
      if (dir == DIR_LEFT) begin
         mapped = rot_amt_t'(0) - amt;
      end else begin
         mapped = amt;
      end
      return mapped;
   endfunction

endpackage

// File: rtl/rot_stream_rot.sv
// Purely combinational 8-bit rotate-right by a 3-bit amount.
module rot
   import rot_stream_pkg::*;
(
   input  rot_data_t data,
   input  rot_amt_t  amt,
   output rot_data_t result
);

   // Output bit i takes input bit (i + amt) mod 8; the 3-bit index wraps naturally.
   always_comb begin
      result = '0;
      for (int i = 0; i < ROT_W; i++) begin
         result[i] = data[AMT_W'(i) + amt];
      end
   end

endmodule

// File: rtl/rot_stream.sv
// Rotates incoming bytes and queues the results in a small FIFO with
// valid/ready handshakes on both sides and a completed-transfer counter.
module rot_stream
   import rot_stream_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROT_W-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROT_W-1:0] out_data,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [PTR_W:0] occupancy;
   rot_data_t      mem [DEPTH];
   rot_data_t      rotated;
   rot_amt_t       eff_amt;
   logic           push;
   logic           pop;

   assign eff_amt = map_amt(in_dir, in_amt);

   rot u_rot (
      .data   (in_data),
      .amt    (eff_amt),
      .result (rotated)
   );

   // Pointers carry one extra wrap bit so full and empty differ in occupancy.
   assign occupancy = wr_ptr - rd_ptr;
   assign in_ready  = !rst && (occupancy < (PTR_W+1)'(DEPTH));
   assign out_valid = (occupancy != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         done_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            done_cnt <= done_cnt + 1'b1;
         end
      end
   end

   // Storage needs no reset: an entry is only visible once the pointers cover it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PTR_W-1:0]] <= rotated;
      end
   end

endmodule

// File: tb/tb_rot_stream.sv
// Self-checking bench for rot_stream: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_rot_stream;

   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic [2:0]       in_amt;
   logic             in_dir;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [CNT_W-1:0] done_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  modelQ[$];
   int unsigned modelDone = 0;

   rot_stream #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [7:0] refRotate(input logic [7:0] d, input logic [2:0] amt, input logic dir);
      int v;
      int a;
      int r;
      v = int'(d);
      a = int'(amt);
      if (a == 0) begin
         r = v;
      end else if (dir) begin
         r = ((v << a) | (v >> (8 - a))) & 255;
      end else begin
         r = ((v >> a) | (v << (8 - a))) & 255;
      end
      return r[7:0];
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic [2:0] a,
                                input logic dir, input logic ordy);
      logic       expReady;
      logic       expValid;
      logic [7:0] expData;
      in_valid  = iv;
      in_data   = d;
      in_amt    = a;
      in_dir    = dir;
      out_ready = ordy;
      #1;
      expReady = (modelQ.size() < DEPTH);
      expValid = (modelQ.size() > 0);
      expData  = expValid ? modelQ[0] : 8'h00;
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expValid});
      checkOutput("out_data", {24'b0, out_data}, {24'b0, expData});
      checkOutput("done_cnt", {16'b0, done_cnt}, {16'b0, modelDone[15:0]});
      @(posedge clk);
      if (ordy && expValid) begin
         void'(modelQ.pop_front());
         modelDone++;
      end
      if (iv && expReady) begin
         modelQ.push_back(refRotate(d, a, dir));
      end
      @(negedge clk);
   endtask

   // Assert reset mid-cycle, check the immediate asynchronous effect, then release.
   task automatic doReset();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("rst_done_cnt", {16'b0, done_cnt}, 32'd0);
      checkOutput("rst_out_data", {24'b0, out_data}, 32'd0);
      modelQ.delete();
      modelDone = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] d;
      int unsigned baseDone;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_amt    = 3'd0;
      in_dir    = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      doReset();

      // B4 rotated right by 3 appears one cycle later and is consumed
      applyStimulus(1'b1, 8'hB4, 3'd3, 1'b0, 1'b1);
      checkOutput("b4_right3", {24'b0, out_data}, 32'h96);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("b4_done", {16'b0, done_cnt}, 32'd1);

      // Left rotates, including amount zero
      applyStimulus(1'b1, 8'h81, 3'd1, 1'b1, 1'b1);
      checkOutput("81_left1", {24'b0, out_data}, 32'h03);
      applyStimulus(1'b1, 8'h81, 3'd0, 1'b1, 1'b1);
      checkOutput("81_left0", {24'b0, out_data}, 32'h81);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // Back-pressure: three pushes into a two-entry buffer
      applyStimulus(1'b1, 8'h11, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 3'd2, 1'b1, 1'b0);
      checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 8'h33, 3'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 3'd5, 1'b0, 1'b0);
      // Full with both sides active: no bypass, one pop, then push accepted
      applyStimulus(1'b1, 8'h33, 3'd5, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h33, 3'd5, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("bp_all_out", {16'b0, done_cnt}, {16'b0, modelDone[15:0]});

      // Steady stream: one result per cycle once primed
      applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b1);
      baseDone = modelDone;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b1);
      end
      checkOutput("stream_done", {16'b0, done_cnt}, baseDone + 32'd20);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // Reset with two entries buffered discards them
      applyStimulus(1'b1, 8'hA5, 3'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h5A, 3'd6, 1'b1, 1'b0);
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         applyStimulus(1'($urandom_range(0, 3) != 0), d, 3'($urandom),
                       1'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
